// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        HALTED   = 2'd3
    } hz_state_t;

    // Select width: 0 = regfile, k+1 = forwarding source k
    function automatic int unsigned fsel_width(input int unsigned nfwd);
        return $clog2(nfwd + 1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side bundle of the hazard controller: status inputs, latch controls, operand selects.
interface hazard_ctrl_unit_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned NFWD   = 2,
    parameter int unsigned SCNT_W = 16
) ();
    import hazard_pkg::*;

    localparam int unsigned FSEL_W = fsel_width(NFWD);

    logic                   ihit;
    logic                   dhit;
    logic                   halt;
    logic                   mem_req;
    logic                   branch_flush;
    logic                   jump_flush;
    logic [REG_AW-1:0]      id_rs;
    logic [REG_AW-1:0]      id_rt;
    logic                   id_uses_rt;
    logic                   ex_is_load;
    logic                   ex_regwr;
    logic [REG_AW-1:0]      ex_wsel;
    logic [REG_AW-1:0]      ex_rs;
    logic [REG_AW-1:0]      ex_rt;
    logic [NFWD-1:0]        fwd_regwr;
    logic [NFWD*REG_AW-1:0] fwd_wsel;

    logic                   ifid_en;
    logic                   ifid_flush;
    logic                   idex_en;
    logic                   idex_flush;
    logic                   exmem_en;
    logic                   exmem_flush;
    logic                   memwb_en;
    logic                   pc_wen;
    logic [FSEL_W-1:0]      forward_a;
    logic [FSEL_W-1:0]      forward_b;
    logic                   halted;
    logic [SCNT_W-1:0]      stall_cycles;

    modport master (
        input  ihit, dhit, halt, mem_req, branch_flush, jump_flush,
               id_rs, id_rt, id_uses_rt, ex_is_load, ex_regwr, ex_wsel,
               ex_rs, ex_rt, fwd_regwr, fwd_wsel,
        output ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
               memwb_en, pc_wen, forward_a, forward_b, halted, stall_cycles
    );

    modport slave (
        output ihit, dhit, halt, mem_req, branch_flush, jump_flush,
               id_rs, id_rt, id_uses_rt, ex_is_load, ex_regwr, ex_wsel,
               ex_rs, ex_rt, fwd_regwr, fwd_wsel,
        input  ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
               memwb_en, pc_wen, forward_a, forward_b, halted, stall_cycles
    );

endinterface

// File: rtl/hazard_ctrl_unit_fwd_select.sv
// Priority matcher: picks the youngest forwarding source writing the operand register.
module fwd_select
    import hazard_pkg::*;
#(
    parameter  int unsigned REG_AW = 5,
    parameter  int unsigned NFWD   = 2,
    localparam int unsigned FSEL_W = fsel_width(NFWD)
) (
    input  logic [NFWD-1:0]        i_regwr,
    input  logic [NFWD*REG_AW-1:0] i_wsel,
    input  logic [REG_AW-1:0]      i_addr,
    output logic [FSEL_W-1:0]      o_sel
);

    always_comb begin
        logic w_found;
        w_found = 1'b0;
        o_sel   = '0;
        for (int unsigned k = 0; k < NFWD; k++) begin
            if (!w_found && i_regwr[k] &&
                (i_wsel[k*REG_AW +: REG_AW] != '0) &&
                (i_wsel[k*REG_AW +: REG_AW] == i_addr)) begin
                w_found = 1'b1;
                o_sel   = FSEL_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller: operand forwarding, load-use bubbles, memory-wait freeze, sticky halt.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned NFWD     = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned SCNT_W   = 16
) (
    input logic               CLK,
    input logic               RST,
    hazard_ctrl_unit_if.master hz
);

    localparam int unsigned FSEL_W  = fsel_width(NFWD);
    // Detect cycle is the first bubble; the counter holds the bubbles still owed after it
    localparam logic [1:0]  LU_INIT = (LOAD_LAT > 0) ? 2'(LOAD_LAT - 1) : 2'd0;

    hz_state_t         r_state, r_ret_state, w_next_state, w_next_ret;
    logic [1:0]        r_lu_cnt, w_next_lu_cnt;
    logic [SCNT_W-1:0] r_stall_cnt;
    logic [FSEL_W-1:0] w_fwd_a, w_fwd_b;
    logic              w_lu, w_flush, w_mwait;
    logic              w_ifid_en, w_ifid_flush, w_idex_en, w_idex_flush;
    logic              w_exmem_en, w_exmem_flush, w_memwb_en, w_pc_wen, w_halted;

    fwd_select #(.REG_AW(REG_AW), .NFWD(NFWD)) u_fwd_a (
        .i_regwr (hz.fwd_regwr),
        .i_wsel  (hz.fwd_wsel),
        .i_addr  (hz.ex_rs),
        .o_sel   (w_fwd_a)
    );

    fwd_select #(.REG_AW(REG_AW), .NFWD(NFWD)) u_fwd_b (
        .i_regwr (hz.fwd_regwr),
        .i_wsel  (hz.fwd_wsel),
        .i_addr  (hz.ex_rt),
        .o_sel   (w_fwd_b)
    );

    assign w_flush = hz.branch_flush | hz.jump_flush;
    assign w_mwait = hz.mem_req & ~hz.dhit;
    assign w_lu    = (LOAD_LAT != 0) && hz.ex_is_load && hz.ex_regwr && (hz.ex_wsel != '0) &&
                     ((hz.ex_wsel == hz.id_rs) || (hz.id_uses_rt && (hz.ex_wsel == hz.id_rt)));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= RUN;
            r_ret_state <= RUN;
            r_lu_cnt    <= '0;
        end else begin
            r_state     <= w_next_state;
            r_ret_state <= w_next_ret;
            r_lu_cnt    <= w_next_lu_cnt;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_ret    = r_ret_state;
        w_next_lu_cnt = r_lu_cnt;
        unique case (r_state)
            RUN: begin
                if (hz.halt) begin
                    w_next_state = HALTED;
                end else if (w_mwait) begin
                    w_next_state = MEM_WAIT;
                    w_next_ret   = RUN;
                end else if (!w_flush && w_lu && hz.ihit && (LU_INIT != 2'd0)) begin
                    w_next_state  = LU_STALL;
                    w_next_lu_cnt = LU_INIT;
                end
            end
            LU_STALL: begin
                if (hz.halt) begin
                    w_next_state = HALTED;
                end else if (w_mwait) begin
                    w_next_state = MEM_WAIT;
                    w_next_ret   = LU_STALL;
                end else if (w_flush) begin
                    w_next_state = RUN;
                end else if (hz.ihit) begin
                    if (r_lu_cnt <= 2'd1) w_next_state = RUN;
                    w_next_lu_cnt = r_lu_cnt - 2'd1;
                end
            end
            MEM_WAIT: begin
                if (hz.halt)      w_next_state = HALTED;
                else if (hz.dhit) w_next_state = r_ret_state;
            end
            HALTED: w_next_state = HALTED;
            default: w_next_state = RUN;
        endcase
    end

    always_comb begin
        w_ifid_en     = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_en     = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_en    = 1'b0;
        w_exmem_flush = 1'b0;
        w_memwb_en    = 1'b0;
        w_pc_wen      = 1'b0;
        w_halted      = 1'b0;
        if (!RST) begin
            unique case (r_state)
                RUN: begin
                    w_ifid_en     = hz.ihit;
                    w_idex_en     = hz.ihit;
                    w_exmem_en    = hz.ihit | hz.dhit;
                    w_memwb_en    = hz.ihit | hz.dhit;
                    w_pc_wen      = hz.ihit;
                    w_ifid_flush  = w_flush;
                    w_idex_flush  = w_flush;
                    w_exmem_flush = hz.dhit;
                    if (w_lu && !w_flush) begin
                        w_ifid_en    = 1'b0;
                        w_pc_wen     = 1'b0;
                        w_idex_flush = 1'b1;
                    end
                end
                LU_STALL: begin
                    w_idex_en    = hz.ihit;
                    w_idex_flush = 1'b1;
                    w_ifid_flush = w_flush;
                    w_exmem_en   = hz.ihit | hz.dhit;
                    w_memwb_en   = hz.ihit | hz.dhit;
                end
                MEM_WAIT: begin
                    w_exmem_en    = hz.dhit;
                    w_memwb_en    = hz.dhit;
                    w_exmem_flush = hz.dhit;
                end
                HALTED: w_halted = 1'b1;
                default: w_halted = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (!w_pc_wen && (r_state != HALTED) && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + SCNT_W'(1);
        end
    end

    assign hz.ifid_en      = w_ifid_en;
    assign hz.ifid_flush   = w_ifid_flush;
    assign hz.idex_en      = w_idex_en;
    assign hz.idex_flush   = w_idex_flush;
    assign hz.exmem_en     = w_exmem_en;
    assign hz.exmem_flush  = w_exmem_flush;
    assign hz.memwb_en     = w_memwb_en;
    assign hz.pc_wen       = w_pc_wen;
    assign hz.halted       = w_halted;
    assign hz.forward_a    = RST ? '0 : w_fwd_a;
    assign hz.forward_b    = RST ? '0 : w_fwd_b;
    assign hz.stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit with NFWD=3, LOAD_LAT=2, SCNT_W=3.
module tb_hazard_ctrl_unit;
    import hazard_pkg::*;

    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NFWD     = 3;
    localparam int unsigned LOAD_LAT = 2;
    localparam int unsigned SCNT_W   = 3;

    // ctrl = {ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, pc_wen, halted}
    localparam logic [8:0] C_ZERO   = 9'b000000000;
    localparam logic [8:0] C_RUN    = 9'b101010110;
    localparam logic [8:0] C_STALL  = 9'b001110100;
    localparam logic [8:0] C_FLUSH  = 9'b111110110;
    localparam logic [8:0] C_DHIT   = 9'b000011100;
    localparam logic [8:0] C_HALTED = 9'b000000001;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [8:0] ctrl;

    hazard_ctrl_unit_if #(.REG_AW(REG_AW), .NFWD(NFWD), .SCNT_W(SCNT_W)) hz ();

    hazard_ctrl_unit #(.REG_AW(REG_AW), .NFWD(NFWD), .LOAD_LAT(LOAD_LAT), .SCNT_W(SCNT_W)) dut (
        .CLK (clk),
        .RST (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    assign ctrl = {hz.ifid_en, hz.ifid_flush, hz.idex_en, hz.idex_flush, hz.exmem_en,
                   hz.exmem_flush, hz.memwb_en, hz.pc_wen, hz.halted};

    task automatic idle_inputs();
        hz.ihit = 1'b1; hz.dhit = 1'b0; hz.halt = 1'b0; hz.mem_req = 1'b0;
        hz.branch_flush = 1'b0; hz.jump_flush = 1'b0;
        hz.id_rs = '0; hz.id_rt = '0; hz.id_uses_rt = 1'b0;
        hz.ex_is_load = 1'b0; hz.ex_regwr = 1'b0; hz.ex_wsel = '0;
        hz.ex_rs = '0; hz.ex_rt = '0; hz.fwd_regwr = '0; hz.fwd_wsel = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use();
        hz.ex_is_load = 1'b1; hz.ex_regwr = 1'b1; hz.ex_wsel = 5'd3; hz.id_rs = 5'd3;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        hz.fwd_regwr = 3'b001; hz.fwd_wsel = {5'd0, 5'd0, 5'd5}; hz.ex_rs = 5'd5;
        next_cycle(); next_cycle(); #1;
        checks++; if (ctrl !== C_ZERO) begin errors++; $display("FAIL reset_ctrl: got %b want %b", ctrl, C_ZERO); end
        checks++; if (hz.forward_a !== 2'd0) begin errors++; $display("FAIL reset_fwd_a: got %0d want 0", hz.forward_a); end
        checks++; if (hz.stall_cycles !== 3'd0) begin errors++; $display("FAIL reset_scnt: got %0d want 0", hz.stall_cycles); end
        rst = 1'b0;
        idle_inputs();
        next_cycle(); #1;
        checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL release_ctrl: got %b want %b", ctrl, C_RUN); end
        checks++; if (hz.stall_cycles !== 3'd0) begin errors++; $display("FAIL release_scnt: got %0d want 0", hz.stall_cycles); end
    endtask

    task automatic test_forward();
        next_cycle();
        hz.fwd_regwr = 3'b101; hz.fwd_wsel = {5'd5, 5'd0, 5'd5}; hz.ex_rs = 5'd5; hz.ex_rt = 5'd0;
        #1;
        checks++; if (hz.forward_a !== 2'd1) begin errors++; $display("FAIL fwd_prio: got %0d want 1", hz.forward_a); end
        checks++; if (hz.forward_b !== 2'd0) begin errors++; $display("FAIL fwd_b_none: got %0d want 0", hz.forward_b); end
        hz.fwd_regwr = 3'b100;
        #1;
        checks++; if (hz.forward_a !== 2'd3) begin errors++; $display("FAIL fwd_src2: got %0d want 3", hz.forward_a); end
        next_cycle();
        hz.fwd_regwr = 3'b111; hz.fwd_wsel = {5'd9, 5'd7, 5'd0}; hz.ex_rs = 5'd0; hz.ex_rt = 5'd7;
        #1;
        checks++; if (hz.forward_a !== 2'd0) begin errors++; $display("FAIL fwd_r0: got %0d want 0", hz.forward_a); end
        checks++; if (hz.forward_b !== 2'd2) begin errors++; $display("FAIL fwd_b_src1: got %0d want 2", hz.forward_b); end
        idle_inputs();
    endtask

    task automatic test_load_use();
        next_cycle();
        hz.ex_is_load = 1'b1; hz.ex_regwr = 1'b1; hz.ex_wsel = 5'd3;
        hz.id_rs = 5'd4; hz.id_rt = 5'd3; hz.id_uses_rt = 1'b0;
        #1;
        checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL lu_rt_unused: got %b want %b", ctrl, C_RUN); end
        hz.id_uses_rt = 1'b1;
        #1;
        checks++; if (ctrl !== C_STALL) begin errors++; $display("FAIL lu_rt_used: got %b want %b", ctrl, C_STALL); end
        idle_inputs();
        next_cycle();
        set_load_use();
        #1;
        checks++; if (ctrl !== C_STALL) begin errors++; $display("FAIL lu_detect: got %b want %b", ctrl, C_STALL); end
        checks++; if (hz.stall_cycles !== 3'd0) begin errors++; $display("FAIL lu_scnt0: got %0d want 0", hz.stall_cycles); end
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (ctrl !== C_STALL) begin errors++; $display("FAIL lu_bubble2: got %b want %b", ctrl, C_STALL); end
        next_cycle(); #1;
        checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL lu_resume: got %b want %b", ctrl, C_RUN); end
        checks++; if (hz.stall_cycles !== 3'd2) begin errors++; $display("FAIL lu_scnt: got %0d want 2", hz.stall_cycles); end
    endtask

    task automatic test_flush_vs_lu();
        next_cycle();
        set_load_use();
        hz.branch_flush = 1'b1;
        #1;
        checks++; if (ctrl !== C_FLUSH) begin errors++; $display("FAIL flush_lu: got %b want %b", ctrl, C_FLUSH); end
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL flush_no_stall: got %b want %b", ctrl, C_RUN); end
        checks++; if (hz.stall_cycles !== 3'd2) begin errors++; $display("FAIL flush_scnt: got %0d want 2", hz.stall_cycles); end
    endtask

    task automatic test_mem_wait_in_lu();
        next_cycle();
        set_load_use();
        #1;
        checks++; if (ctrl !== C_STALL) begin errors++; $display("FAIL mw_detect: got %b want %b", ctrl, C_STALL); end
        next_cycle();
        idle_inputs();
        hz.mem_req = 1'b1;
        #1;
        checks++; if (ctrl !== C_STALL) begin errors++; $display("FAIL mw_lu_req: got %b want %b", ctrl, C_STALL); end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            hz.fwd_regwr = 3'b001; hz.fwd_wsel = {5'd0, 5'd0, 5'd5}; hz.ex_rs = 5'd5;
            #1;
            checks++; if (ctrl !== C_ZERO) begin errors++; $display("FAIL mw_freeze%0d: got %b want %b", i, ctrl, C_ZERO); end
            checks++; if (hz.forward_a !== 2'd1) begin errors++; $display("FAIL mw_fwd%0d: got %0d want 1", i, hz.forward_a); end
        end
        next_cycle();
        hz.dhit = 1'b1;
        #1;
        checks++; if (ctrl !== C_DHIT) begin errors++; $display("FAIL mw_dhit: got %b want %b", ctrl, C_DHIT); end
        checks++; if (hz.stall_cycles !== 3'd7) begin errors++; $display("FAIL mw_scnt: got %0d want 7", hz.stall_cycles); end
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (ctrl !== C_STALL) begin errors++; $display("FAIL mw_ret_lu: got %b want %b", ctrl, C_STALL); end
        next_cycle(); #1;
        checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL mw_lu_done: got %b want %b", ctrl, C_RUN); end
        checks++; if (hz.stall_cycles !== 3'd7) begin errors++; $display("FAIL sat_scnt: got %0d want 7", hz.stall_cycles); end
    endtask

    task automatic test_halt();
        next_cycle();
        hz.halt = 1'b1;
        #1;
        checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL halt_req: got %b want %b", ctrl, C_RUN); end
        next_cycle();
        hz.halt = 1'b0;
        #1;
        checks++; if (ctrl !== C_HALTED) begin errors++; $display("FAIL halted: got %b want %b", ctrl, C_HALTED); end
        next_cycle(); #1;
        checks++; if (ctrl !== C_HALTED) begin errors++; $display("FAIL halted_sticky: got %b want %b", ctrl, C_HALTED); end
        rst = 1'b1;
        #1;
        checks++; if (ctrl !== C_ZERO) begin errors++; $display("FAIL halt_rst: got %b want %b", ctrl, C_ZERO); end
        next_cycle(); #1;
        checks++; if (hz.stall_cycles !== 3'd0) begin errors++; $display("FAIL halt_rst_scnt: got %0d want 0", hz.stall_cycles); end
        rst = 1'b0;
        next_cycle(); #1;
        checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL halt_rst_run: got %b want %b", ctrl, C_RUN); end
    endtask

    task automatic test_halt_freeze();
        next_cycle();
        hz.ihit = 1'b0;
        #1;
        checks++; if (ctrl !== C_ZERO) begin errors++; $display("FAIL nohit: got %b want %b", ctrl, C_ZERO); end
        next_cycle();
        hz.ihit = 1'b1; hz.halt = 1'b1;
        #1;
        checks++; if (hz.stall_cycles !== 3'd1) begin errors++; $display("FAIL nohit_scnt: got %0d want 1", hz.stall_cycles); end
        next_cycle();
        hz.halt = 1'b0;
        next_cycle(); next_cycle(); #1;
        checks++; if (ctrl !== C_HALTED) begin errors++; $display("FAIL freeze_halted: got %b want %b", ctrl, C_HALTED); end
        checks++; if (hz.stall_cycles !== 3'd1) begin errors++; $display("FAIL freeze_scnt: got %0d want 1", hz.stall_cycles); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_flush_vs_lu();
        test_mem_wait_in_lu();
        test_halt();
        test_halt_freeze();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
